// File: rtl/lisa_qqspi_arbiter.sv
// Two-port (instruction fetch I, data D) arbiter in front of one lisa_qqspi controller.
// Define LISA_QQSPI_ARB_RR_EN for round-robin tie-break; default is fixed priority D over I.
module lisa_qqspi_arbiter #(
  parameter int CHIP_SELECTS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic [23:0]             i_addr,
  input  logic [3:0]              i_len,
  input  logic [CHIP_SELECTS-1:0] i_cs,
  output logic                    i_word,
  output logic [15:0]             i_rdata,
  output logic                    i_done,
  input  logic                    d_valid,
  input  logic [23:0]             d_addr,
  input  logic [3:0]              d_len,
  input  logic [CHIP_SELECTS-1:0] d_cs,
  input  logic [15:0]             d_wdata,
  input  logic [1:0]              d_wstrb,
  input  logic                    d_ack,
  output logic                    d_word,
  output logic [15:0]             d_rdata,
  output logic                    d_done,
  output logic [23:0]             m_addr,
  output logic [15:0]             m_wdata,
  output logic [1:0]              m_wstrb,
  output logic [3:0]              m_xfer_len,
  output logic [CHIP_SELECTS-1:0] m_ce_ctrl,
  output logic                    m_valid,
  output logic                    m_ready_ack,
  input  logic                    m_ready,
  input  logic                    m_xfer_done,
  input  logic [15:0]             m_rdata,
  output logic [1:0]              grant,
  output logic [1:0]              dbg_state
);

  // Handshake: a requester holds *_valid and its fields until *_done; m_valid is
  // held from grant until m_xfer_done, and a new grant is only issued once the
  // controller has dropped m_ready, so two requests never overlap on the controller.
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RELEASE = 2'd2} state_t;

  state_t state;
  logic   m_ready_q;
  logic   pick_d;

`ifdef LISA_QQSPI_ARB_RR_EN
  logic last_owner;  // 1 = D last granted, 0 = I
  always_comb pick_d = d_valid & (~i_valid | ~last_owner);
`else
  always_comb pick_d = d_valid;
`endif

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 2'b00;
      m_valid   <= 1'b0;
      m_ready_q <= 1'b0;
      i_word    <= 1'b0;
      d_word    <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
`ifdef LISA_QQSPI_ARB_RR_EN
      last_owner <= 1'b0;
`endif
    end else begin
      m_ready_q <= m_ready;
      i_word    <= 1'b0;
      d_word    <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (!m_ready && (i_valid || d_valid)) begin
            grant   <= pick_d ? 2'b10 : 2'b01;
            m_valid <= 1'b1;
            state   <= XFER;
`ifdef LISA_QQSPI_ARB_RR_EN
            last_owner <= pick_d;
`endif
          end
        end
        XFER: begin
          // Each rising edge of m_ready marks one word delivered/consumed.
          if (m_ready && !m_ready_q) begin
            i_word <= grant[0];
            d_word <= grant[1];
          end
          if (m_xfer_done) begin
            m_valid <= 1'b0;
            i_done  <= grant[0];
            d_done  <= grant[1];
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          if (!m_ready) begin
            grant <= 2'b00;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_addr     = '0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_xfer_len = '0;
    m_ce_ctrl  = '0;
    if (grant[1]) begin
      m_addr     = d_addr;
      m_wdata    = d_wdata;
      m_wstrb    = d_wstrb;
      m_xfer_len = d_len;
      m_ce_ctrl  = d_cs;
    end else if (grant[0]) begin
      // Fetch port is read-only: write data and strobes stay zero.
      m_addr     = i_addr;
      m_xfer_len = i_len;
      m_ce_ctrl  = i_cs;
    end
  end

  assign m_ready_ack = grant[1] & d_ack;
  assign i_rdata     = m_rdata;
  assign d_rdata     = m_rdata;

endmodule
